// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial wide adder: state encoding,
// nibble width and the iteration-counter width helper.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-nibble build still needs a 1-bit counter.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_adder.sv
// Existing 4-bit combinational adder that the serial front end drives one
// nibble at a time.
module Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);

  logic [4:0] total;

  assign total = 5'(A) + 5'(B) + 5'(CIN);
  assign SUM   = total[3:0];
  assign COUT  = total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit Adder, processing one nibble per cycle
// (LS nibble first) between a valid/ready input and a valid/ready output.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [NIBBLE_W*NIBBLES-1:0]   A,
  input  logic [NIBBLE_W*NIBBLES-1:0]   B,
  input  logic                          CIN,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [NIBBLE_W*NIBBLES-1:0]   SUM,
  output logic                          COUT
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  state_e               state_q, state_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [W-1:0]         sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic                 cout_q, cout_d;
  logic [CNT_W-1:0]     idx_q, idx_d;

  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_cout;

  // Select the active nibble of each captured operand.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == CNT_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  Adder u_adder (
    .A    (a_nib),
    .B    (b_nib),
    .CIN  (carry_q),
    .SUM  (nib_sum),
    .COUT (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == CNT_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
          end
        end
        carry_d = nib_cout;
        // The counter parks on the last nibble rather than wrapping.
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: 4-nibble and 1-nibble builds
// compared against plain wide-integer addition.
module tb_nibble_serial_adder;

  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int N1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, cin_in, out_valid, out_ready, cout;
  logic [W-1:0]  a_in, b_in, sum;

  logic          n_in_valid, n_in_ready, n_cin, n_out_valid, n_out_ready, n_cout;
  logic [3:0]    n_a, n_b, n_sum;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a_in), .B(b_in), .CIN(cin_in),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .SUM(sum), .COUT(cout)
  );

  nibble_serial_adder #(.NIBBLES(N1)) dut1 (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(n_in_valid), .IN_READY(n_in_ready),
    .A(n_a), .B(n_b), .CIN(n_cin),
    .OUT_VALID(n_out_valid), .OUT_READY(n_out_ready),
    .SUM(n_sum), .COUT(n_cout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full transaction on the 4-nibble build, holding the result for
  // 'hold' cycles of backpressure before consuming it.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input int hold);
    logic [W:0] full;
    int cycles;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    cin_in    = cin;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cycles   = 1;
    while (!out_valid && cycles < 4 * N) begin
      a_in      = W'($urandom);
      b_in      = W'($urandom);
      cin_in    = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;
    checkOutput("latency", 32'(cycles), 32'(N + 1));
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("sum", 32'(sum), 32'(full[W-1:0]));
    checkOutput("cout", 32'(cout), 32'(full[W]));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      @(negedge clk);
      checkOutput("hold_sum", 32'(sum), 32'(full[W-1:0]));
      checkOutput("hold_cout", 32'(cout), 32'(full[W]));
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic applyStimulusNarrow(input logic [3:0] a, input logic [3:0] b,
                                     input logic cin);
    logic [4:0] full;
    int cycles;
    full = {1'b0, a} + {1'b0, b} + 5'(cin);
    n_in_valid  = 1'b1;
    n_a         = a;
    n_b         = b;
    n_cin       = cin;
    n_out_ready = 1'b0;
    @(negedge clk);
    n_in_valid = 1'b0;
    cycles     = 1;
    while (!n_out_valid && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("n_latency", 32'(cycles), 32'(N1 + 1));
    checkOutput("n_sum", 32'(n_sum), 32'(full[3:0]));
    checkOutput("n_cout", 32'(n_cout), 32'(full[4]));
    n_out_ready = 1'b1;
    @(negedge clk);
    n_out_ready = 1'b0;
    checkOutput("n_release_in_ready", 32'(n_in_ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a_in        = '0;
    b_in        = '0;
    cin_in      = 1'b0;
    n_in_valid  = 1'b0;
    n_out_ready = 1'b0;
    n_a         = '0;
    n_b         = '0;
    n_cin       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    checkOutput("reset_n_in_ready", 32'(n_in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'h0003, 16'h000C, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1);
    applyStimulus(16'hFFFD, 16'hFFFF, 1'b1, 6);

    // Reset two cycles into an operation.
    in_valid = 1'b1;
    a_in     = 16'hABCD;
    b_in     = 16'h9876;
    cin_in   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrun_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrun_sum", 32'(sum), 32'd0);
    checkOutput("midrun_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h1234, 16'h4321, 1'b0, 0);

    for (int t = 0; t < 20; t++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)));
    end

    applyStimulusNarrow(4'b1111, 4'b1101, 1'b1);
    for (int t = 0; t < 8; t++) begin
      applyStimulusNarrow(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
